// File: rtl/msg_frame_rx_if.sv
// msg_frame_rx_if: FIFO-side and OPB-side signals of the frame receiver
interface msg_frame_rx_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          RX_FIFO_RD;
  logic [7:0]    RX_FIFO_DATA;
  logic          RX_FIFO_EMPTY;
  logic [AW-1:0] OPB_ADDR;
  logic [DW-1:0] OPB_DO;
  logic          OPB_WE;
  logic          OPB_RE;
  logic          OPB_ACK;
  logic          ERR_STB;
  logic [1:0]    ERR_CODE;
  logic          FRAME_OK;
  modport master (
    output RX_FIFO_RD, OPB_ADDR, OPB_DO, OPB_WE, OPB_RE, ERR_STB, ERR_CODE, FRAME_OK,
    input  RX_FIFO_DATA, RX_FIFO_EMPTY, OPB_ACK
  );
  modport slave (
    input  RX_FIFO_RD, OPB_ADDR, OPB_DO, OPB_WE, OPB_RE, ERR_STB, ERR_CODE, FRAME_OK,
    output RX_FIFO_DATA, RX_FIFO_EMPTY, OPB_ACK
  );
endinterface

// File: rtl/msg_frame_rx.sv
// msg_frame_rx: parses header|addr|data|csum|tail frames from a FWFT FIFO and issues OPB requests
module msg_frame_rx #(
  parameter int          ADDR_BYTES     = 4,
  parameter int          DATA_BYTES     = 4,
  parameter bit          CSUM_EN        = 1'b1,
  parameter logic [7:0]  HDR_WR         = 8'h5A,
  parameter logic [7:0]  HDR_RD         = 8'h5B,
  parameter int          TIMEOUT_CYCLES = 200000
) (
  input logic OPB_CLK,
  input logic OPB_RST,
  msg_frame_rx_if.master bus
);
  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {HUNT, ADDR, DATA, CSUM, TAIL, ISSUE, WAIT, ERR} state_t;
  state_t        r_state;
  logic [7:0]    r_hdr;
  logic [7:0]    r_csum;
  logic [2:0]    r_cnt;
  logic [TW-1:0] r_to;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_do;
  logic          r_we;
  logic          r_re;
  logic          r_err_stb;
  logic [1:0]    r_err_code;
  logic          r_frame_ok;
  logic          w_frame;
  logic          w_pop;
  logic          w_to;
  logic [7:0]    w_byte;
  assign w_frame = r_state inside {ADDR, DATA, CSUM, TAIL};
  assign w_pop   = !bus.RX_FIFO_EMPTY && (w_frame || r_state == HUNT);
  assign w_byte  = bus.RX_FIFO_DATA;
  // the idle cycle that would bring the counter to TIMEOUT_CYCLES-1 drops the frame; a pop on it wins
  assign w_to    = w_frame && !w_pop && r_to == TW'(TIMEOUT_CYCLES - 2);
  assign bus.RX_FIFO_RD = w_pop;
  assign bus.OPB_ADDR   = r_addr;
  assign bus.OPB_DO     = r_do;
  assign bus.OPB_WE     = r_we;
  assign bus.OPB_RE     = r_re;
  assign bus.ERR_STB    = r_err_stb;
  assign bus.ERR_CODE   = r_err_code;
  assign bus.FRAME_OK   = r_frame_ok;
  // frame parser, request handshake and error reporting; error pulses are raised on entry to ERR
  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      r_state    <= HUNT;
      r_hdr      <= '0;
      r_csum     <= '0;
      r_cnt      <= '0;
      r_to       <= '0;
      r_addr     <= '0;
      r_do       <= '0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_err_stb  <= 1'b0;
      r_err_code <= '0;
      r_frame_ok <= 1'b0;
    end else begin
      r_err_stb  <= 1'b0;
      r_frame_ok <= 1'b0;
      r_to       <= (w_frame && !w_pop) ? r_to + TW'(1) : '0;
      if (w_to) begin
        r_state    <= ERR;
        r_err_stb  <= 1'b1;
        r_err_code <= 2'd2;
        r_cnt      <= '0;
      end else begin
        case (r_state)
          HUNT: if (w_pop && (w_byte == HDR_WR || w_byte == HDR_RD)) begin
            r_hdr   <= w_byte;
            r_csum  <= w_byte;
            r_state <= ADDR;
          end
          ADDR: if (w_pop) begin
            r_addr  <= AW'({r_addr, w_byte});
            r_csum  <= r_csum ^ w_byte;
            r_cnt   <= (r_cnt == 3'(ADDR_BYTES - 1)) ? 3'd0 : r_cnt + 3'd1;
            r_state <= (r_cnt == 3'(ADDR_BYTES - 1)) ? DATA : ADDR;
          end
          DATA: if (w_pop) begin
            r_do    <= DW'({r_do, w_byte});
            r_csum  <= r_csum ^ w_byte;
            r_cnt   <= (r_cnt == 3'(DATA_BYTES - 1)) ? 3'd0 : r_cnt + 3'd1;
            r_state <= (r_cnt != 3'(DATA_BYTES - 1)) ? DATA : CSUM_EN ? CSUM : TAIL;
          end
          CSUM: if (w_pop) begin
            r_state    <= (w_byte == r_csum) ? TAIL : ERR;
            r_err_stb  <= (w_byte != r_csum);
            r_err_code <= (w_byte == r_csum) ? r_err_code : 2'd3;
          end
          TAIL: if (w_pop) begin
            r_state    <= (w_byte == ~r_hdr) ? ISSUE : ERR;
            r_err_stb  <= (w_byte != ~r_hdr);
            r_err_code <= (w_byte == ~r_hdr) ? r_err_code : 2'd1;
          end
          ISSUE: begin
            r_we    <= (r_hdr == HDR_WR);
            r_re    <= (r_hdr == HDR_RD);
            r_state <= WAIT;
          end
          WAIT: if (bus.OPB_ACK) begin
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_frame_ok <= 1'b1;
            r_state    <= HUNT;
          end
          ERR: begin
            r_cnt   <= '0;
            r_state <= HUNT;
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_msg_frame_rx.sv
// tb_msg_frame_rx: directed vector table, corner sequences and a randomized run against a frame-level model
module tb_msg_frame_rx;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  msg_frame_rx_if #(.AW(32), .DW(32)) ifa ();
  msg_frame_rx_if #(.AW(16), .DW(8))  ifb ();
  msg_frame_rx #(.ADDR_BYTES(4), .DATA_BYTES(4), .CSUM_EN(1'b1), .TIMEOUT_CYCLES(TO))
    u_a (.OPB_CLK(clk), .OPB_RST(rst), .bus(ifa));
  msg_frame_rx #(.ADDR_BYTES(2), .DATA_BYTES(1), .CSUM_EN(1'b0), .TIMEOUT_CYCLES(TO))
    u_b (.OPB_CLK(clk), .OPB_RST(rst), .bus(ifb));
  int g_ab[2] = '{4, 2};
  int g_db[2] = '{4, 1};
  int g_ce[2] = '{1, 0};
  typedef struct { logic [15:0][7:0] b; int len; } frame_t;
  typedef struct {
    int d; logic [7:0] hdr; logic [31:0] a; logic [31:0] dt; int junk; bit bcs; bit btl;
    bit ewe; bit ere; logic [31:0] eaddr; logic [31:0] edo; int eerr; int eok; logic [1:0] ecode;
  } vec_t;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit gate[2];
  bit ack[2];
  bit ird[2], owe[2], ore[2], ostb[2], ook[2];
  logic [1:0] ocode[2];
  logic [31:0] oaddr[2], odo[2];
  logic [7:0] m_buf[2][16];
  int m_n[2], m_idle[2];
  bit m_issue[2], m_busy[2], m_errc[2], m_we[2], m_re[2], m_stb[2], m_ok[2], m_rd[2];
  logic [1:0] m_code[2];
  logic [31:0] m_addr[2], m_do[2];
  int n_tests = 0;
  int n_fail = 0;
  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d got %h want %h at %0t", nm, d, act, exp, $time);
    end
  endtask
  function automatic frame_t mk(int d, logic [7:0] h, logic [31:0] a, logic [31:0] dt,
                                int junk, logic [7:0] jb, bit bcs, bit btl);
    frame_t f;
    logic [7:0] x;
    f.b = '0;
    f.len = 0;
    for (int k = 0; k < junk; k++) begin f.b[f.len] = jb + 8'(17 * k); f.len++; end
    f.b[f.len] = h; f.len++;
    x = h;
    for (int i = g_ab[d] - 1; i >= 0; i--) begin f.b[f.len] = a[8*i +: 8]; x ^= a[8*i +: 8]; f.len++; end
    for (int i = g_db[d] - 1; i >= 0; i--) begin f.b[f.len] = dt[8*i +: 8]; x ^= dt[8*i +: 8]; f.len++; end
    if (g_ce[d] == 1) begin f.b[f.len] = bcs ? ~x : x; f.len++; end
    f.b[f.len] = btl ? (~h ^ 8'h01) : ~h;
    f.len++;
    return f;
  endfunction
  task automatic push(int d, frame_t f, int from, int upto);
    for (int i = from; i < upto && i < f.len; i++)
      if (d == 0) qa.push_back(f.b[i]); else qb.push_back(f.b[i]);
  endtask
  task automatic m_err(int d, logic [1:0] c);
    m_stb[d] = 1'b1; m_code[d] = c; m_errc[d] = 1'b1; m_n[d] = 0; m_idle[d] = 0;
  endtask
  // frame-level reference: bytes collected into a buffer, frame judged by its position and content
  task automatic m_step(int d, logic [7:0] b, bit a);
    int L;
    logic [7:0] x;
    L = 2 + g_ab[d] + g_db[d] + g_ce[d];
    if (rst) begin
      m_n[d] = 0; m_idle[d] = 0; m_issue[d] = 0; m_busy[d] = 0; m_errc[d] = 0;
      m_we[d] = 0; m_re[d] = 0; m_stb[d] = 0; m_ok[d] = 0; m_code[d] = 0; m_addr[d] = 0; m_do[d] = 0;
      return;
    end
    m_stb[d] = 1'b0;
    m_ok[d] = 1'b0;
    if (m_errc[d]) m_errc[d] = 1'b0;
    else if (m_issue[d]) begin
      m_issue[d] = 1'b0; m_busy[d] = 1'b1;
      m_we[d] = (m_buf[d][0] == 8'h5A); m_re[d] = !m_we[d];
    end else if (m_busy[d]) begin
      if (a) begin m_busy[d] = 0; m_we[d] = 0; m_re[d] = 0; m_ok[d] = 1; end
    end else if (m_rd[d]) begin
      m_idle[d] = 0;
      if (m_n[d] == 0) begin
        if (b == 8'h5A || b == 8'h5B) begin m_buf[d][0] = b; m_n[d] = 1; end
      end else begin
        m_buf[d][m_n[d]] = b;
        m_n[d]++;
        x = '0;
        for (int i = 0; i < m_n[d] - 1; i++) x ^= m_buf[d][i];
        if (g_ce[d] == 1 && m_n[d] == L - 1 && b != x) m_err(d, 2'd3);
        else if (m_n[d] == L) begin
          if (b == ~m_buf[d][0]) begin
            m_issue[d] = 1'b1; m_n[d] = 0; m_addr[d] = 0; m_do[d] = 0;
            for (int i = 1; i <= g_ab[d]; i++) m_addr[d] = (m_addr[d] << 8) | 32'(m_buf[d][i]);
            for (int i = 1 + g_ab[d]; i <= g_ab[d] + g_db[d]; i++) m_do[d] = (m_do[d] << 8) | 32'(m_buf[d][i]);
          end else m_err(d, 2'd1);
        end
      end
    end else if (m_n[d] > 0) begin
      m_idle[d]++;
      if (m_idle[d] == TO - 1) m_err(d, 2'd2);
    end
  endtask
  task automatic cyc();
    bit e[2];
    logic [7:0] b[2];
    e[0] = gate[0] || qa.size() == 0;
    e[1] = gate[1] || qb.size() == 0;
    b[0] = qa.size() > 0 ? qa[0] : 8'h00;
    b[1] = qb.size() > 0 ? qb[0] : 8'h00;
    ifa.RX_FIFO_EMPTY = e[0]; ifa.RX_FIFO_DATA = b[0]; ifa.OPB_ACK = ack[0];
    ifb.RX_FIFO_EMPTY = e[1]; ifb.RX_FIFO_DATA = b[1]; ifb.OPB_ACK = ack[1];
    #1;
    ird[0] = ifa.RX_FIFO_RD;
    ird[1] = ifb.RX_FIFO_RD;
    for (int d = 0; d < 2; d++) begin
      m_rd[d] = !e[d] && !m_issue[d] && !m_busy[d] && !m_errc[d];
      chk("rd", d, ird[d], m_rd[d]);
      m_step(d, b[d], ack[d]);
    end
    @(posedge clk);
    #1;
    if (ird[0] && qa.size() > 0) void'(qa.pop_front());
    if (ird[1] && qb.size() > 0) void'(qb.pop_front());
    owe[0] = ifa.OPB_WE; ore[0] = ifa.OPB_RE; ostb[0] = ifa.ERR_STB; ook[0] = ifa.FRAME_OK;
    ocode[0] = ifa.ERR_CODE; oaddr[0] = ifa.OPB_ADDR; odo[0] = ifa.OPB_DO;
    owe[1] = ifb.OPB_WE; ore[1] = ifb.OPB_RE; ostb[1] = ifb.ERR_STB; ook[1] = ifb.FRAME_OK;
    ocode[1] = ifb.ERR_CODE; oaddr[1] = 32'(ifb.OPB_ADDR); odo[1] = 32'(ifb.OPB_DO);
    for (int d = 0; d < 2; d++) begin
      chk("we", d, owe[d], m_we[d]);
      chk("re", d, ore[d], m_re[d]);
      chk("err_stb", d, ostb[d], m_stb[d]);
      chk("frame_ok", d, ook[d], m_ok[d]);
      chk("err_code", d, ocode[d], m_code[d]);
      if (m_busy[d] || rst) begin
        chk("addr", d, oaddr[d], m_addr[d]);
        chk("do", d, odo[d], m_do[d]);
      end
    end
    @(negedge clk);
  endtask
  task automatic run_auto(int d, int ncyc, output int errs, output int oks, output bit sw,
                          output bit sr, output logic [31:0] ca, output logic [31:0] cd);
    int hi;
    hi = 0; errs = 0; oks = 0; sw = 0; sr = 0; ca = 0; cd = 0;
    for (int c = 0; c < ncyc; c++) begin
      ack[d] = (hi >= 3);
      cyc();
      ack[d] = 1'b0;
      if (owe[d] || ore[d]) begin hi++; sw |= owe[d]; sr |= ore[d]; ca = oaddr[d]; cd = odo[d]; end
      else hi = 0;
      errs += int'(ostb[d]);
      oks += int'(ook[d]);
    end
  endtask
  vec_t tbl[9];
  initial begin
    frame_t f;
    int errs, oks, n, sz;
    bit sw, sr;
    logic [31:0] ca, cd;
    int gcnt[2];
    tbl[0] = '{0, 8'h5A, 32'h00001004, 32'hDEADBEEF, 0, 0, 0, 1, 0, 32'h00001004, 32'hDEADBEEF, 0, 1, 2'd0};
    tbl[1] = '{0, 8'h5B, 32'h00000008, 32'h00000000, 2, 0, 0, 0, 1, 32'h00000008, 32'h00000000, 0, 1, 2'd0};
    tbl[2] = '{0, 8'h5A, 32'h00001004, 32'hDEADBEEF, 0, 0, 1, 0, 0, 32'h0, 32'h0, 1, 0, 2'd1};
    tbl[3] = '{0, 8'h5A, 32'hCAFEF00D, 32'h12345678, 0, 0, 0, 1, 0, 32'hCAFEF00D, 32'h12345678, 0, 1, 2'd1};
    tbl[4] = '{0, 8'h5A, 32'h00000010, 32'h00000001, 0, 1, 0, 0, 0, 32'h0, 32'h0, 1, 0, 2'd3};
    tbl[5] = '{0, 8'h5B, 32'hFFFFFFFF, 32'hA5A5A5A5, 1, 0, 0, 0, 1, 32'hFFFFFFFF, 32'hA5A5A5A5, 0, 1, 2'd3};
    tbl[6] = '{1, 8'h5A, 32'h00001234, 32'h00000056, 0, 0, 0, 1, 0, 32'h00001234, 32'h00000056, 0, 1, 2'd0};
    tbl[7] = '{1, 8'h5B, 32'h0000ABCD, 32'h000000EF, 0, 0, 1, 0, 0, 32'h0, 32'h0, 1, 0, 2'd1};
    tbl[8] = '{1, 8'h5B, 32'h0000ABCD, 32'h000000EF, 2, 0, 0, 0, 1, 32'h0000ABCD, 32'h000000EF, 0, 1, 2'd1};
    gate = '{0, 0};
    ack = '{0, 0};
    gcnt = '{0, 0};
    @(negedge clk);
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    for (int v = 0; v < 9; v++) begin
      push(tbl[v].d, mk(tbl[v].d, tbl[v].hdr, tbl[v].a, tbl[v].dt, tbl[v].junk, 8'h11, tbl[v].bcs, tbl[v].btl), 0, 16);
      run_auto(tbl[v].d, 60, errs, oks, sw, sr, ca, cd);
      chk($sformatf("vec%0d_we", v), tbl[v].d, sw, tbl[v].ewe);
      chk($sformatf("vec%0d_re", v), tbl[v].d, sr, tbl[v].ere);
      chk($sformatf("vec%0d_errs", v), tbl[v].d, errs, tbl[v].eerr);
      chk($sformatf("vec%0d_oks", v), tbl[v].d, oks, tbl[v].eok);
      chk($sformatf("vec%0d_code", v), tbl[v].d, tbl[v].d == 0 ? ocode[0] : ocode[1], tbl[v].ecode);
      if (tbl[v].ewe || tbl[v].ere) begin
        chk($sformatf("vec%0d_addr", v), tbl[v].d, ca, tbl[v].eaddr);
        chk($sformatf("vec%0d_do", v), tbl[v].d, cd, tbl[v].edo);
      end
    end
    f = mk(0, 8'h5A, 32'h00001004, 32'hDEADBEEF, 0, 8'h00, 0, 0);
    push(0, f, 0, 4);
    for (int c = 0; c < 20 && qa.size() > 0; c++) cyc();
    n = 0;
    do begin cyc(); n++; end while (!ostb[0] && n < 40);
    chk("timeout_cycles", 0, n, 15);
    chk("timeout_code", 0, ocode[0], 2);
    cyc();
    push(0, f, 0, 4);
    for (int c = 0; c < 20 && qa.size() > 0; c++) cyc();
    n = 0;
    for (int c = 0; c < 14; c++) begin cyc(); n += int'(ostb[0]); end
    push(0, f, 4, 16);
    run_auto(0, 40, errs, oks, sw, sr, ca, cd);
    chk("late_byte_errs", 0, errs + n, 0);
    chk("late_byte_ok", 0, oks, 1);
    chk("late_byte_addr", 0, ca, 32'h00001004);
    push(0, f, 0, 16);
    push(0, mk(0, 8'h5B, 32'h00000077, 32'h0, 0, 8'h00, 0, 0), 0, 16);
    ack[0] = 1'b0;
    for (int c = 0; c < 40 && !owe[0]; c++) cyc();
    chk("bp_we_up", 0, owe[0], 1);
    sz = qa.size();
    for (int c = 0; c < 50; c++) begin cyc(); chk("bp_rd_low", 0, ird[0], 0); end
    chk("bp_we_held", 0, owe[0], 1);
    chk("bp_fifo_untouched", 0, qa.size(), sz);
    run_auto(0, 80, errs, oks, sw, sr, ca, cd);
    chk("bp_oks", 0, oks, 2);
    chk("bp_second_read", 0, sr, 1);
    chk("bp_drained", 0, qa.size(), 0);
    push(0, f, 0, 3);
    for (int c = 0; c < 20 && qa.size() > 0; c++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_we", 0, owe[0], 0);
    chk("rst_re", 0, ore[0], 0);
    chk("rst_stb", 0, ostb[0], 0);
    chk("rst_ok", 0, ook[0], 0);
    chk("rst_code", 0, ocode[0], 0);
    chk("rst_addr", 0, oaddr[0], 0);
    chk("rst_do", 0, odo[0], 0);
    push(0, mk(0, 8'h5B, 32'h00C0FFEE, 32'h0, 0, 8'h00, 0, 0), 0, 16);
    run_auto(0, 40, errs, oks, sw, sr, ca, cd);
    chk("post_rst_ok", 0, oks, 1);
    chk("post_rst_errs", 0, errs, 0);
    chk("post_rst_addr", 0, ca, 32'h00C0FFEE);
    for (int c = 0; c < 4000; c++) begin
      for (int d = 0; d < 2; d++) begin
        if ((d == 0 ? qa.size() : qb.size()) < 4 && $urandom_range(0, 3) == 0) begin
          n = $urandom_range(0, 9);
          push(d, mk(d, $urandom_range(0, 1) == 1 ? 8'h5A : 8'h5B, $urandom, $urandom,
                     $urandom_range(0, 2), 8'($urandom), n == 0, n == 1), 0, 16);
        end
        if (gcnt[d] > 0) begin gate[d] = 1'b1; gcnt[d]--; end
        else begin
          gate[d] = ($urandom_range(0, 7) == 0);
          if ($urandom_range(0, 59) == 0) gcnt[d] = $urandom_range(5, 25);
        end
        ack[d] = ($urandom_range(0, 3) == 0);
      end
      rst = ($urandom_range(0, 799) == 0);
      cyc();
    end
    rst = 1'b0;
    gate = '{0, 0};
    ack = '{0, 0};
    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/msg_frame_rx.md
Name: msg_frame_rx

Overview:
- Parametrised successor of the fixed 10-byte OPB message parser.
- Pops bytes from the UART RX FIFO and assembles frames of the form header | ADDR_BYTES address | DATA_BYTES data | optional XOR checksum | tail. It then issues one OPB read or write per valid frame.
- Adds three behaviours:
  - Header resynchronisation: junk bytes before a header are discarded.
  - An inter-byte timeout counted in OPB_CLK cycles.
  - An OPB acknowledge handshake, with FIFO back-pressure while a transfer is outstanding.
- Error reporting is coded, not a bare flag.

Parameters:
- ADDR_BYTES, 4: address bytes per frame (1..4), MSB first. Address width AW = 8*ADDR_BYTES.
- DATA_BYTES, 4: data bytes per frame (1..4), MSB first. Data width DW = 8*DATA_BYTES.
- CSUM_EN, 1: 1 = a checksum byte precedes the tail; 0 = no checksum byte.
- HDR_WR, 8'h5A: header byte for a write frame.
- HDR_RD, 8'h5B: header byte for a read frame.
- TIMEOUT_CYCLES, 200000: maximum number of consecutive FIFO-empty cycles allowed inside a frame.

Ports:
- OPB_CLK  in  1  sole clock.
- OPB_RST  in  1  synchronous, active-high reset.
- RX_FIFO_RD  out  1  pop strobe, combinational.
- RX_FIFO_DATA  in  8  first-word-fall-through data; valid whenever RX_FIFO_EMPTY=0.
- RX_FIFO_EMPTY  in  1  FIFO empty.
- OPB_ADDR  out  AW  transfer address.
- OPB_DO  out  DW  write data.
- OPB_WE  out  1  write request, held until acknowledged.
- OPB_RE  out  1  read request, held until acknowledged.
- OPB_ACK  in  1  transfer complete, single-cycle pulse.
- ERR_STB  out  1  one-cycle pulse when a frame is dropped.
- ERR_CODE  out  2  last error: 0 none, 1 tail, 2 timeout, 3 checksum.
- FRAME_OK  out  1  one-cycle pulse on the cycle OPB_ACK is accepted.

Behaviour:
- Reset state: all outputs 0, state HUNT, all counters 0. Reset mid-frame discards the partial frame and any request in flight; bytes already popped are lost.
- Pop rule: RX_FIFO_RD = !RX_FIFO_EMPTY && state in {HUNT, ADDR, DATA, CSUM, TAIL}. No pop in ISSUE, WAIT or ERR; the FIFO back-pressures.
- HUNT state:
  - A popped byte equal to HDR_WR or HDR_RD is latched as hdr, seeds the checksum (csum <= byte), and moves to ADDR.
  - Any other byte is discarded and the block stays in HUNT, with no error.
- ADDR state:
  - Each pop shifts the byte into OPB_ADDR from the MSB down and XORs it into csum.
  - The byte counter reaches ADDR_BYTES, then the block moves to DATA.
- DATA state:
  - Same shift-and-XOR into OPB_DO.
  - After DATA_BYTES pops: go to CSUM if CSUM_EN=1, else to TAIL.
- CSUM state: on pop, the byte must equal csum. Match goes to TAIL; mismatch goes to ERR with code 3.
- TAIL state: on pop, the byte must equal ~hdr. Match goes to ISSUE; mismatch goes to ERR with code 1.
- ISSUE state (one cycle): registers OPB_WE=1 if hdr==HDR_WR, or OPB_RE=1 if hdr==HDR_RD, then moves to WAIT.
- WAIT state:
  - The request is held, and OPB_ADDR and OPB_DO are stable, until OPB_ACK.
  - On OPB_ACK: drop the request next cycle, pulse FRAME_OK, return to HUNT.
  - OPB_ACK outside WAIT is ignored.
  - WAIT has no timeout.
- ERR state (one cycle): pulses ERR_STB, updates ERR_CODE, clears the counters, returns to HUNT. OPB_WE and OPB_RE are never asserted for a bad frame.
- ERR_CODE holds its value until the next error or reset.
- Timeout counter:
  - Active only in ADDR/DATA/CSUM/TAIL. Cleared on every pop and in every other state.
  - Increments on each cycle with no pop. When it reaches TIMEOUT_CYCLES-1 with no pop, go to ERR with code 2.
  - If a pop coincides with the limit cycle, the pop wins and the counter clears.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
- Byte counter width is 3 bits; it clears on every state change.
- Latency:
  - Tail pop to OPB_WE/OPB_RE high: 2 cycles (TAIL→ISSUE, ISSUE registers the request).
  - OPB_ACK to request low: 1 cycle.
- Back-to-back frames: the next header may already sit in the FIFO; it is popped on the first HUNT cycle after FRAME_OK.

Test Plan:
- Write, defaults: FIFO holds 5A 00 00 10 04 DE AD BE EF cs A5, with cs = XOR of the first 9 bytes. Required: OPB_WE=1, OPB_ADDR=0x00001004, OPB_DO=0xDEADBEEF, held until OPB_ACK; FRAME_OK pulses once.
- Resync and read: FIFO holds 11 22 5B 00 00 00 08 00 00 00 00 cs A4. Required: 11 and 22 dropped with no ERR_STB; OPB_RE=1 with OPB_ADDR=0x00000008.
- Bad tail: a valid write frame with tail A4. Required: ERR_STB once, ERR_CODE=1, OPB_WE never asserts, next good frame accepted.
- Bad checksum, and CSUM_EN=0 variant:
  - cs byte inverted: ERR_CODE=3.
  - Rebuilt with CSUM_EN=0, ADDR_BYTES=2, DATA_BYTES=1: frame 5A 12 34 56 A5 gives OPB_ADDR=0x1234, OPB_DO=0x56.
- Timeout: TIMEOUT_CYCLES=16; stop feeding after the 3rd address byte. Required: ERR_CODE=2 exactly 15 idle cycles after the last pop. Separately, a byte arriving on cycle 15 prevents the error.
- Back-pressure and reset:
  - Hold OPB_ACK low for 50 cycles with a second frame queued: RX_FIFO_RD stays 0 throughout.
  - Assert OPB_RST mid-ADDR: all outputs go to 0 next cycle, and the next frame parses cleanly.
